// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator gain-compensation shifter.
// Holds the gain-computation FSM state encoding and the helper functions
// that derive the headroom, shift and product widths from N and RW.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_LOG  = 2'd2,
    ST_DONE = 2'd3
  } cic_state_e;

  // Input headroom bits: the CIC gain is rate^(N-1), at most (N-1)*RW bits.
  function automatic int max_bit_gain(input int n, input int rw);
    return (n - 1) * rw;
  endfunction

  // Width of the shift value; never narrower than one bit.
  function automatic int shift_width(input int mbg);
    return (mbg < 1) ? 1 : $clog2(mbg + 1);
  endfunction

  // Width of the running product p = r^(N-1).
  function automatic int prod_width(input int n, input int rw);
    return (n - 1) * rw;
  endfunction

endpackage

// File: rtl/cic_int_shifter_pipe_round_sat.sv
// round_sat: combinational round-half-up arithmetic right shift followed by
// saturation to a signed BW-bit range.
//   x_i   : signed IW-bit input sample
//   s_i   : right-shift amount (0 passes the sample straight through)
//   y_o   : signed BW-bit result
//   sat_o : high when the result was clipped
module round_sat #(
  parameter int IW = 40,
  parameter int BW = 16,
  parameter int SW = 5
) (
  input  logic signed [IW-1:0] x_i,
  input  logic        [SW-1:0] s_i,
  output logic signed [BW-1:0] y_o,
  output logic                 sat_o
);

  localparam logic signed [IW:0] MAXV = {{(IW-BW+2){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [IW:0] MINV = {{(IW-BW+2){1'b1}}, {(BW-1){1'b0}}};

  // One extra bit so the rounding add cannot overflow.
  logic signed [IW:0] xe;
  logic signed [IW:0] bias;
  logic signed [IW:0] sum;
  logic signed [IW:0] res;

  always_comb begin
    xe   = {x_i[IW-1], x_i};
    bias = '0;
    if (s_i != '0) begin
      bias = {{IW{1'b0}}, 1'b1} << (s_i - 1'b1);
    end
    sum   = xe + bias;
    res   = sum >>> s_i;
    y_o   = res[BW-1:0];
    sat_o = 1'b0;
    if (res > MAXV) begin
      y_o   = MAXV[BW-1:0];
      sat_o = 1'b1;
    end else if (res < MINV) begin
      y_o   = MINV[BW-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/cic_int_shifter_pipe.sv
// cic_int_shifter_pipe: gain compensation for a CIC interpolator.
// A small FSM computes shift = ceil((N-1)*log2(rate)) by repeated
// multiplication then a linear log search; a 2-stage valid/ready pipeline
// applies a rounding, saturating right shift to each integrator sample.
//   clock, reset_n          : clock (rising edge), async active-low reset
//   rate, rate_stb          : interpolation rate and its one-cycle load pulse
//   busy, shift             : gain computation active / shift in force
//   in_data/valid/ready     : IW-bit signed samples in
//   out_data/valid/ready    : BW-bit signed samples out, sat flags clipping
module cic_int_shifter_pipe
  import cic_pkg::*;
#(
  parameter int BW         = 16,
  parameter int N          = 4,
  parameter int RW         = 8,
  parameter int MAXBITGAIN = max_bit_gain(N, RW),
  parameter int SW         = shift_width(MAXBITGAIN)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic        [RW-1:0]           rate,
  input  logic                           rate_stb,
  output logic                           busy,
  output logic        [SW-1:0]           shift,
  input  logic signed [BW+MAXBITGAIN-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic signed [BW-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sat
);

  localparam int IW = BW + MAXBITGAIN;
  localparam int PW = prod_width(N, RW);

  // ---------------- gain computation FSM ----------------
  cic_state_e    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [PW-1:0] p_q, p_d;
  logic [SW-1:0] g_q, g_d;
  logic [2:0]    mcnt_q, mcnt_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [RW-1:0] rate_eff;
  logic [PW:0]   pow2;
  logic          log_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      r_q     <= RW'(1);
      p_q     <= PW'(1);
      g_q     <= '0;
      mcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      g_q     <= g_d;
      mcnt_q  <= mcnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    rate_eff = (rate == '0) ? RW'(1) : rate;
    pow2     = {{PW{1'b0}}, 1'b1} << g_q;
    // The MAXBITGAIN cap only matters if the parameter is overridden below
    // (N-1)*RW; it keeps the search bounded within the shift range.
    log_done = (pow2 >= {1'b0, p_q}) || (g_q == SW'(MAXBITGAIN));

    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    g_d     = g_q;
    mcnt_d  = mcnt_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (rate_stb) begin
          r_d     = rate_eff;
          p_d     = PW'(rate_eff);
          mcnt_d  = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        p_d    = p_q * PW'(r_q);
        mcnt_d = mcnt_q + 1'b1;
        if (mcnt_q == 3'(N - 3)) begin
          g_d     = '0;
          state_d = ST_LOG;
        end
      end
      ST_LOG: begin
        if (log_done) state_d = ST_DONE;
        else          g_d     = g_q + 1'b1;
      end
      ST_DONE: begin
        shift_d = g_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    shift = shift_q;
  end

  // ---------------- sample pipeline ----------------
  logic                 rdy_en_q;
  logic                 s1_v_q;
  logic signed [IW-1:0] s1_x_q;
  logic        [SW-1:0] s1_s_q;
  logic                 s2_v_q;
  logic signed [BW-1:0] s2_y_q;
  logic                 s2_sat_q;
  logic signed [BW-1:0] rs_y;
  logic                 rs_sat;
  logic                 s2_free, s1_adv, s1_free, in_acc;

  always_comb begin
    s2_free  = !s2_v_q || out_ready;
    s1_adv   = s1_v_q && s2_free;
    s1_free  = !s1_v_q || s2_free;
    in_ready = rdy_en_q && !busy && s1_free;
    in_acc   = in_valid && in_ready;
  end

  round_sat #(.IW(IW), .BW(BW), .SW(SW)) u_round_sat (
    .x_i   (s1_x_q),
    .s_i   (s1_s_q),
    .y_o   (rs_y),
    .sat_o (rs_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_s_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_y_q   <= '0;
      s2_sat_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      // Each sample carries the shift that was in force when it was accepted.
      if (in_acc) begin
        s1_v_q <= 1'b1;
        s1_x_q <= in_data;
        s1_s_q <= shift_q;
      end else if (s1_adv) begin
        s1_v_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_v_q   <= 1'b1;
        s2_y_q   <= rs_y;
        s2_sat_q <= rs_sat;
      end else if (out_ready) begin
        s2_v_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = s2_v_q;
    out_data  = s2_y_q;
    sat       = s2_sat_q;
  end

endmodule

// File: tb/tb_cic_int_shifter_pipe.sv
module tb_cic_int_shifter_pipe;

  localparam int BW  = 16;
  localparam int N   = 4;
  localparam int RW  = 8;
  localparam int MBG = (N - 1) * RW;
  localparam int SW  = $clog2(MBG + 1);
  localparam int IW  = BW + MBG;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic        [RW-1:0] rate = '0;
  logic                 rate_stb = 1'b0;
  logic                 busy;
  logic        [SW-1:0] shift;
  logic signed [IW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 sat;

  cic_int_shifter_pipe #(.BW(BW), .N(N), .RW(RW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rate      (rate),
    .rate_stb  (rate_stb),
    .busy      (busy),
    .shift     (shift),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint y;
    bit     s;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   model_shift = 0;
  bit   lat_chk = 1'b0;
  bit   rand_rdy = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Smallest g with 2^g >= rate^(N-1).
  function automatic int ref_shift(input int r);
    longint rr, p;
    int g;
    rr = (r == 0) ? 1 : r;
    p = 1;
    for (int i = 0; i < N - 1; i++) p = p * rr;
    g = 0;
    while ((longint'(1) << g) < p) g++;
    return g;
  endfunction

  // floor((x + 2^(s-1)) / 2^s), then clamp to the BW-bit signed range.
  function automatic exp_t ref_out(input longint x, input int s);
    exp_t   e;
    longint d, num, q, hi, lo;
    if (s == 0) q = x;
    else begin
      d   = longint'(1) << s;
      num = x + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
    end
    hi  = (longint'(1) << (BW - 1)) - 1;
    lo  = -(longint'(1) << (BW - 1));
    e.s = 1'b0;
    if (q > hi) begin q = hi; e.s = 1'b1; end
    else if (q < lo) begin q = lo; e.s = 1'b1; end
    e.y   = q;
    e.cyc = 0;
    return e;
  endfunction

  // Input monitor: every accepted sample pushes its expected result.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && in_valid && in_ready) begin
      e     = ref_out(longint'(in_data), model_shift);
      e.cyc = cyc;
      sb.push_back(e);
      acc_cnt++;
    end
  end

  // Output monitor: pops and compares on every output handshake.
  bit                   prev_stall = 1'b0;
  logic signed [BW-1:0] prev_d;
  logic                 prev_s;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_data", longint'(out_data), longint'(prev_d));
        chk("hold_sat", longint'(sat), longint'(prev_s));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d expected no output", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", longint'(out_data), e.y);
          chk("out_sat", longint'(sat), longint'(e.s));
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_s     = sat;
    end
  end

  always @(posedge clock) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input longint x);
    bit acc;
    in_valid = 1'b1;
    in_data  = IW'(x);
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic load_rate(input int r, input int intr_at, input int intr_rate);
    int exp_g, exp_busy, cnt;
    bit rdy_seen;
    exp_g    = ref_shift(r);
    exp_busy = (N - 2) + (exp_g + 1) + 1;
    rate     = RW'(r);
    rate_stb = 1'b1;
    @(posedge clock);
    #1;
    rate_stb = 1'b0;
    cnt      = 0;
    rdy_seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
      if (in_ready) rdy_seen = 1'b1;
      if (cnt == intr_at) begin
        rate     = RW'(intr_rate);
        rate_stb = 1'b1;
      end else begin
        rate_stb = 1'b0;
      end
    end
    rate_stb = 1'b0;
    chk("busy_len", cnt, exp_busy);
    chk("shift", longint'(shift), exp_g);
    chk("in_ready_busy", longint'(rdy_seen), 0);
    model_shift = exp_g;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  function automatic longint rand_sample(input int s);
    longint span;
    case ($urandom_range(0, 2))
      0: return longint'({$urandom, $urandom});
      1: begin
        span = longint'(1) << (BW + s + 1);
        return longint'({$urandom, $urandom} % span) - span / 2;
      end
      default: return longint'($urandom_range(0, 128)) - 64;
    endcase
  endfunction

  initial begin
    int a0, gaps;
    bit acc;

    // Reset values before any clock edge.
    #2;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_shift", longint'(shift), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    #20;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("in_ready_after_rst", longint'(in_ready), 1);

    // Gain computation corner rates.
    load_rate(128, 0, 0);
    chk("shift_128", longint'(shift), 21);
    load_rate(3, 0, 0);
    chk("shift_3", longint'(shift), 5);
    load_rate(1, 0, 0);
    load_rate(0, 0, 0);

    // Rounding at shift 3.
    load_rate(2, 0, 0);
    lat_chk = 1'b1;
    send(12);
    send(-12);
    send(11);
    in_valid = 1'b0;
    drain();

    // Saturation at shift 0.
    load_rate(1, 0, 0);
    send(40000);
    send(-40000);
    send(100);
    in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Second strobe during LOG is ignored.
    load_rate(128, 5, 3);
    chk("ignored_stb_shift", longint'(shift), 21);

    // Output stall with continuous input.
    a0        = acc_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = IW'(rand_sample(model_shift));
    repeat (5) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (acc) in_data = IW'(rand_sample(model_shift));
    end
    @(negedge clock);
    chk("stall_accepted", acc_cnt - a0, 2);
    chk("stall_in_ready", longint'(in_ready), 0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    gaps      = 0;
    repeat (8) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      if (!out_valid) gaps++;
      @(posedge clock);
      #1;
      if (acc) in_data = IW'(rand_sample(model_shift));
    end
    chk("release_gaps", gaps, 0);
    in_valid = 1'b0;
    drain();

    // Reset during MUL with a stalled output sample.
    out_ready = 1'b0;
    send(777);
    in_valid = 1'b0;
    rate     = RW'(200);
    rate_stb = 1'b1;
    @(posedge clock);
    #1;
    rate_stb = 1'b0;
    #2;
    chk("pre_rst_busy", longint'(busy), 1);
    chk("pre_rst_out_valid", longint'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_shift", longint'(shift), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    @(negedge clock);
    @(posedge clock);
    #2;
    reset_n     = 1'b1;
    model_shift = 0;
    out_ready   = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    chk("post_rst_shift", longint'(shift), 0);
    chk("post_rst_busy", longint'(busy), 0);

    // Randomized traffic with random backpressure and random rates.
    rand_rdy = 1'b1;
    repeat (5) begin
      in_valid = 1'b0;
      load_rate(int'($urandom_range(0, 255)), 0, 0);
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clock);
          #1;
        end
        send(rand_sample(model_shift));
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_int_shifter_pipe.md
CIC_INT_SHIFTER_PIPE -- requirements
Module: cic_int_shifter_pipe

Interface
REQ-001 Parameter BW, default 16: signed output sample width.
REQ-002 Parameter N, default 4, range 3..6: CIC stage count; gain exponent is N-1.
REQ-003 Parameter RW, default 8: rate port width.
REQ-004 Parameter MAXBITGAIN, default (N-1)*RW: input headroom bits; input width IW = BW+MAXBITGAIN.
REQ-005 Parameter SW, default clog2(MAXBITGAIN+1): shift width.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 rate  in  RW  interpolation rate, equal to the actual rate; 0 is treated as 1.
REQ-009 rate_stb  in  1  one-cycle pulse that loads rate.
REQ-010 busy  out  1  gain computation in progress.
REQ-011 shift  out  SW  currently applied right-shift.
REQ-012 in_data/in_valid/in_ready  in/in/out  IW/1/1  signed integrator output, valid/ready.
REQ-013 out_data/out_valid/out_ready  out/out/in  BW/1/1  shifted signed sample, valid/ready.
REQ-014 sat  out  1  qualifies out_data; high when that sample was clipped.

Function
REQ-015 Computed shift SHALL be the smallest g with 2^g >= rate^(N-1), i.e. ceil((N-1)*log2(rate)).
REQ-016 FSM states: IDLE, MUL, LOG, DONE.
REQ-017 IDLE: on rate_stb, latch rate into r and set p=r; go to MUL; busy asserts next cycle.
REQ-018 MUL: exactly N-2 cycles, each p=p*r, full (N-1)*RW-bit precision; then go to LOG with g=0.
REQ-019 LOG: each cycle, if 2^g >= p go to DONE, else g=g+1; this takes g_final+1 cycles.
REQ-020 DONE: one cycle; shift<=g; return to IDLE; busy deasserts in the same edge.
REQ-021 busy duration SHALL be exactly (N-2)+(g+1)+1 cycles.
REQ-022 rate_stb while busy SHALL be ignored.
REQ-023 in_ready SHALL be low while busy; samples use the shift in force when accepted.
REQ-024 Datapath: 2-stage pipeline. Stage 1 registers in_data plus its shift. Stage 2 registers the result.
REQ-025 Latency: in-to-out 2 cycles with no stall.
REQ-026 Throughput: 1 sample/cycle.
REQ-027 Stall: a stage advances only when the next stage is empty or emptying this cycle; no loss, no duplication.
REQ-028 Arithmetic, s>0: y = (x + 2^(s-1)) >>> s, computed in IW+1 bits so the rounding add cannot overflow.
REQ-029 Arithmetic, s=0: y = x.
REQ-030 y SHALL saturate to [-2^(BW-1), 2^(BW-1)-1]; sat=1 when clipped.
REQ-031 out_data/sat SHALL hold stable while out_valid && !out_ready.

Reset
REQ-032 On reset_n low, immediately: state=IDLE, busy=0, shift=0, r=1, pipeline empty, out_valid=0, out_data=0, sat=0, in_ready=0.
REQ-033 in_ready=1 from the first clock after reset_n deasserts.
REQ-034 Reset mid-computation or mid-stall SHALL discard all state; no partial shift applied.

Structure
REQ-035 The FSM state encoding and the N/RW/MAXBITGAIN derivation functions SHALL live in shared package cic_pkg.
REQ-036 The round/saturate datapath SHALL be sub-module round_sat (IW in, BW out, combinational, parameterised).

Verification
REQ-037 N=4, RW=8: rate_stb with rate=128 -> busy exactly 25 cycles, then shift=21; rate=3 -> shift=5; rate=1 and rate=0 -> shift=0.
REQ-038 shift=3: in_data=+12 -> out_data=+2; in_data=-12 -> out_data=-1; in_data=+11 -> out_data=+1; all with 2-cycle latency.
REQ-039 BW=16, shift=0: in_data=40000 -> out_data=32767, sat=1; in_data=-40000 -> out_data=-32768, sat=1; in_data=100 -> out_data=100, sat=0.
REQ-040 Continuous in_valid with out_ready low for 5 cycles -> exactly 2 samples accepted, in_ready low, output stable; after release, order is preserved with no gaps or losses.
REQ-041 Second rate_stb during LOG -> ignored, first result applied. reset_n pulsed low during MUL -> busy=0, shift=0, out_valid=0 at once.
